// File: rtl/touch_pkg.sv
// Shared definitions for the touch-controller polling sequencer: register map,
// sequencer states and the coordinate type.
package touch_pkg;

  localparam logic [7:0] REG_TD_STATUS = 8'h02;
  localparam logic [7:0] REG_P1_XH     = 8'h03;
  localparam logic [7:0] REG_P1_XL     = 8'h04;
  localparam logic [7:0] REG_P1_YH     = 8'h05;
  localparam logic [7:0] REG_P1_YL     = 8'h06;

  // Bytes captured per poll: TD_STATUS followed by the four P1 coordinate bytes.
  localparam int NUM_REGS = 5;

  typedef enum logic [2:0] {
    ST_RECOVER,
    ST_WAIT_POLL,
    ST_ISSUE,
    ST_WAIT_RESP,
    ST_GAP,
    ST_PUBLISH
  } state_t;

  typedef logic [11:0] coord_t;

  // Only a count of one or two touches is trusted; 0 and anything above 2
  // (including the 0xF the controller reports while booting) mean no touch.
  function automatic logic touch_present(input logic [7:0] td_status);
    return (td_status[3:0] == 4'd1) || (td_status[3:0] == 4'd2);
  endfunction

endpackage

// File: rtl/touch_poll_ctrl.sv
// Polls a capacitive touch controller through a single-register I2C read engine
// and publishes one coordinate record per poll; recovers the engine on a hang.
module touch_poll_ctrl
  import touch_pkg::*;
#(
  parameter int         POLL_PERIOD = 1_000_000,
  parameter int         TIMEOUT     = 200_000,
  parameter logic [6:0] DEV_ADDR    = 7'h38,
  parameter int         RST_CYCLES  = 4
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       enable_in,
  output logic       i2c_trigger_out,
  output logic [7:0] i2c_reg_out,
  output logic [6:0] i2c_addr_out,
  input  logic [7:0] i2c_data_in,
  input  logic       i2c_valid_in,
  output logic       i2c_rst_out,
  output coord_t     touch_x_out,
  output coord_t     touch_y_out,
  output logic [1:0] touch_event_out,
  output logic       touch_active_out,
  output logic       touch_valid_out,
  output logic       timeout_out
);

  localparam int PCW = (POLL_PERIOD > 1) ? $clog2(POLL_PERIOD) : 1;
  localparam int TCW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int RCW = $clog2(RST_CYCLES + 1);

  localparam logic [PCW-1:0] POLL_LAST = PCW'(POLL_PERIOD - 1);
  localparam logic [TCW-1:0] TMO_LAST  = TCW'(TIMEOUT - 1);
  localparam logic [RCW-1:0] RST_LOAD  = RCW'(RST_CYCLES);

  state_t         state_reg, state_next;
  logic [PCW-1:0] poll_cnt_reg, poll_cnt_next;
  logic [TCW-1:0] tmo_cnt_reg, tmo_cnt_next;
  logic [RCW-1:0] rst_cnt_reg, rst_cnt_next;
  logic [7:0]     reg_idx_reg, reg_idx_next;

  logic [7:0] shadow_reg [NUM_REGS];
  coord_t     x_reg, y_reg;
  logic [1:0] event_reg;
  logic       active_reg;

  logic poll_due;
  logic resp_ok;
  logic resp_tmo;
  logic publish_touch;
  logic publish_none;

  assign poll_due      = enable_in && (poll_cnt_reg == POLL_LAST);
  assign resp_ok       = (state_reg == ST_WAIT_RESP) && i2c_valid_in;
  assign resp_tmo      = (state_reg == ST_WAIT_RESP) && !i2c_valid_in && (tmo_cnt_reg == TMO_LAST);
  assign publish_touch = (state_reg == ST_GAP) && (reg_idx_reg == REG_P1_YL);
  assign publish_none  = (state_reg == ST_GAP) && (reg_idx_reg == REG_TD_STATUS)
                         && !touch_present(shadow_reg[0]);

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_reg    <= ST_RECOVER;
      poll_cnt_reg <= '0;
      tmo_cnt_reg  <= '0;
      rst_cnt_reg  <= RST_LOAD;
      reg_idx_reg  <= '0;
    end else begin
      state_reg    <= state_next;
      poll_cnt_reg <= poll_cnt_next;
      tmo_cnt_reg  <= tmo_cnt_next;
      rst_cnt_reg  <= rst_cnt_next;
      reg_idx_reg  <= reg_idx_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    tmo_cnt_next = tmo_cnt_reg;
    rst_cnt_next = rst_cnt_reg;
    reg_idx_next = reg_idx_reg;

    // Free-running period counter; held during recovery so the first poll after
    // a reset or a hang lands one full period after the engine comes back.
    if ((state_reg == ST_RECOVER) || !enable_in || (poll_cnt_reg == POLL_LAST))
      poll_cnt_next = '0;
    else
      poll_cnt_next = poll_cnt_reg + 1'b1;

    case (state_reg)
      ST_RECOVER: begin
        if (rst_cnt_reg <= 1) begin
          rst_cnt_next = RST_LOAD;
          state_next   = ST_WAIT_POLL;
        end else begin
          rst_cnt_next = rst_cnt_reg - 1'b1;
        end
      end
      ST_WAIT_POLL: begin
        if (poll_due) begin
          reg_idx_next = REG_TD_STATUS;
          state_next   = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tmo_cnt_next = '0;
        state_next   = ST_WAIT_RESP;
      end
      ST_WAIT_RESP: begin
        tmo_cnt_next = tmo_cnt_reg + 1'b1;
        if (i2c_valid_in) begin
          state_next = ST_GAP;
        end else if (tmo_cnt_reg == TMO_LAST) begin
          rst_cnt_next = RST_LOAD;
          state_next   = ST_RECOVER;
        end
      end
      ST_GAP: begin
        if (publish_touch || publish_none) begin
          state_next = ST_PUBLISH;
        end else begin
          reg_idx_next = reg_idx_reg + 8'd1;
          state_next   = ST_ISSUE;
        end
      end
      ST_PUBLISH: state_next = ST_WAIT_POLL;
      default:    state_next = ST_RECOVER;
    endcase
  end

  always_comb begin
    i2c_trigger_out = (state_reg == ST_ISSUE);
    i2c_rst_out     = (state_reg == ST_RECOVER);
    touch_valid_out = (state_reg == ST_PUBLISH);
    timeout_out     = resp_tmo;
  end

  // Shadow bytes for the poll in flight; a hung poll wipes them.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      for (int i = 0; i < NUM_REGS; i++) shadow_reg[i] <= '0;
    end else if (resp_tmo) begin
      for (int i = 0; i < NUM_REGS; i++) shadow_reg[i] <= '0;
    end else if (resp_ok) begin
      for (int i = 0; i < NUM_REGS; i++)
        if (reg_idx_reg == REG_TD_STATUS + 8'(i)) shadow_reg[i] <= i2c_data_in;
    end
  end

  // Published record is updated on the edge into PUBLISH so it is already
  // stable while touch_valid_out is high.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      x_reg      <= '0;
      y_reg      <= '0;
      event_reg  <= '0;
      active_reg <= 1'b0;
    end else if (publish_touch) begin
      x_reg      <= {shadow_reg[1][3:0], shadow_reg[2]};
      y_reg      <= {shadow_reg[3][3:0], shadow_reg[4]};
      event_reg  <= shadow_reg[1][7:6];
      active_reg <= 1'b1;
    end else if (publish_none) begin
      active_reg <= 1'b0;
    end
  end

  assign i2c_reg_out      = reg_idx_reg;
  assign i2c_addr_out     = DEV_ADDR;
  assign touch_x_out      = x_reg;
  assign touch_y_out      = y_reg;
  assign touch_event_out  = event_reg;
  assign touch_active_out = active_reg;

endmodule

// File: tb/tb_touch_poll_ctrl.sv
// Directed bench for touch_poll_ctrl: reset, touch/no-touch polls, timeout
// recovery, async reset mid-transaction and enable drop.
module tb_touch_poll_ctrl;
  import touch_pkg::*;

  localparam int P = 60;
  localparam int T = 20;
  localparam int R = 4;

  logic       clk_in = 1'b0;
  logic       rst_in = 1'b0;
  logic       enable_in = 1'b0;
  logic [7:0] i2c_data_in = 8'h00;
  logic       i2c_valid_in = 1'b0;
  logic       i2c_trigger_out;
  logic [7:0] i2c_reg_out;
  logic [6:0] i2c_addr_out;
  logic       i2c_rst_out;
  coord_t     touch_x_out, touch_y_out;
  logic [1:0] touch_event_out;
  logic       touch_active_out, touch_valid_out, timeout_out;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  touch_poll_ctrl #(
    .POLL_PERIOD(P), .TIMEOUT(T), .DEV_ADDR(7'h38), .RST_CYCLES(R)
  ) dut (
    .clk_in(clk_in), .rst_in(rst_in), .enable_in(enable_in),
    .i2c_trigger_out(i2c_trigger_out), .i2c_reg_out(i2c_reg_out),
    .i2c_addr_out(i2c_addr_out), .i2c_data_in(i2c_data_in),
    .i2c_valid_in(i2c_valid_in), .i2c_rst_out(i2c_rst_out),
    .touch_x_out(touch_x_out), .touch_y_out(touch_y_out),
    .touch_event_out(touch_event_out), .touch_active_out(touch_active_out),
    .touch_valid_out(touch_valid_out), .timeout_out(timeout_out)
  );

  always #5 clk_in = ~clk_in;
  always @(posedge clk_in) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_trigger(input string tag, input int limit, output int n, output int at_cyc);
    logic seen;
    seen = 1'b0;
    n = 0;
    while (!seen && n < limit) begin
      @(negedge clk_in);
      n++;
      if (i2c_trigger_out) seen = 1'b1;
    end
    check({tag, "_seen"}, 32'(seen), 32'd1);
    at_cyc = cyc;
  endtask

  // Entered at the negedge where the trigger was observed.
  task automatic respond(input string tag, input logic [7:0] exp_reg, input logic [7:0] data);
    check({tag, "_reg"}, 32'(i2c_reg_out), 32'(exp_reg));
    @(negedge clk_in);
    check({tag, "_trig1"}, 32'(i2c_trigger_out), 32'd0);
    i2c_data_in  = data;
    i2c_valid_in = 1'b1;
    @(negedge clk_in);
    i2c_valid_in = 1'b0;
    i2c_data_in  = 8'h00;
    check({tag, "_hold"}, 32'(i2c_reg_out), 32'(exp_reg));
    $display("txn %s reg=0x%02h data=0x%02h cyc=%0d", tag, exp_reg, data, cyc);
  endtask

  task automatic do_txn(input string tag, input logic [7:0] exp_reg, input logic [7:0] data);
    int n, c;
    wait_trigger(tag, 8, n, c);
    respond(tag, exp_reg, data);
  endtask

  task automatic check_publish(input string tag, input logic act, input logic [11:0] x,
                               input logic [11:0] y, input logic [1:0] ev);
    @(negedge clk_in);
    check({tag, "_valid"}, 32'(touch_valid_out), 32'd1);
    check({tag, "_active"}, 32'(touch_active_out), 32'(act));
    check({tag, "_x"}, 32'(touch_x_out), 32'(x));
    check({tag, "_y"}, 32'(touch_y_out), 32'(y));
    check({tag, "_event"}, 32'(touch_event_out), 32'(ev));
    @(negedge clk_in);
    check({tag, "_valid_off"}, 32'(touch_valid_out), 32'd0);
    $display("publish %s active=%0d x=0x%03h y=0x%03h ev=%0d", tag, touch_active_out,
             touch_x_out, touch_y_out, touch_event_out);
  endtask

  // Release reset at a negedge, check the recovery pulse and the first trigger.
  task automatic release_and_first_poll(input string tag, input logic late_valid, output int trig_cyc);
    int n;
    rst_in = 1'b1;
    if (late_valid) begin
      i2c_valid_in = 1'b1;
      i2c_data_in  = 8'h01;
    end
    for (int k = 1; k <= R; k++) begin
      @(negedge clk_in);
      i2c_valid_in = 1'b0;
      i2c_data_in  = 8'h00;
      check($sformatf("%s_rst%0d", tag, k), 32'(i2c_rst_out), (k < R) ? 32'd1 : 32'd0);
    end
    wait_trigger({tag, "_first"}, P + 10, n, trig_cyc);
    check({tag, "_first_lat"}, 32'(n + R), 32'(P + R));
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int tprev, tc, n;

    rst_in    = 1'b0;
    enable_in = 1'b1;
    repeat (3) @(negedge clk_in);
    check("rst_trig", 32'(i2c_trigger_out), 32'd0);
    check("rst_i2crst", 32'(i2c_rst_out), 32'd1);
    check("rst_addr", 32'(i2c_addr_out), 32'h38);
    check("rst_reg", 32'(i2c_reg_out), 32'h00);
    check("rst_x", 32'(touch_x_out), 32'd0);
    check("rst_y", 32'(touch_y_out), 32'd0);
    check("rst_valid", 32'(touch_valid_out), 32'd0);
    check("rst_active", 32'(touch_active_out), 32'd0);
    check("rst_timeout", 32'(timeout_out), 32'd0);

    // Touch poll
    release_and_first_poll("boot", 1'b0, tprev);
    respond("p1_st", REG_TD_STATUS, 8'h01);
    do_txn("p1_xh", REG_P1_XH, 8'h81);
    do_txn("p1_xl", REG_P1_XL, 8'h2C);
    do_txn("p1_yh", REG_P1_YH, 8'h00);
    do_txn("p1_yl", REG_P1_YL, 8'hF0);
    check_publish("p1", 1'b1, 12'h12C, 12'h0F0, 2'b10);

    // No-touch poll, count 0
    wait_trigger("p2", P + 10, n, tc);
    check("p2_period", 32'(tc - tprev), 32'(P));
    tprev = tc;
    respond("p2_st", REG_TD_STATUS, 8'h00);
    check_publish("p2", 1'b0, 12'h12C, 12'h0F0, 2'b10);

    // No-touch poll, count 0xF
    wait_trigger("p3", P + 10, n, tc);
    check("p3_period", 32'(tc - tprev), 32'(P));
    tprev = tc;
    respond("p3_st", REG_TD_STATUS, 8'h0F);
    check_publish("p3", 1'b0, 12'h12C, 12'h0F0, 2'b10);

    // Timeout on P1_XL
    wait_trigger("p4", P + 10, n, tc);
    check("p4_period", 32'(tc - tprev), 32'(P));
    respond("p4_st", REG_TD_STATUS, 8'h02);
    do_txn("p4_xh", REG_P1_XH, 8'h45);
    wait_trigger("p4_xl", 8, n, tc);
    check("p4_xl_reg", 32'(i2c_reg_out), 32'(REG_P1_XL));
    for (int k = 1; k <= T; k++) begin
      @(negedge clk_in);
      check($sformatf("p4_tmo%0d", k), 32'(timeout_out), (k == T) ? 32'd1 : 32'd0);
    end
    for (int k = 1; k <= R + 1; k++) begin
      @(negedge clk_in);
      check($sformatf("p4_rec%0d", k), 32'(i2c_rst_out), (k <= R) ? 32'd1 : 32'd0);
      check($sformatf("p4_novalid%0d", k), 32'(touch_valid_out), 32'd0);
    end
    check("p4_x_kept", 32'(touch_x_out), 32'h12C);
    $display("txn p4 timeout recovered cyc=%0d", cyc);

    // Poll after recovery
    wait_trigger("p5", P + 10, n, tprev);
    check("p5_lat", 32'(n), 32'(P));
    respond("p5_st", REG_TD_STATUS, 8'h01);
    do_txn("p5_xh", REG_P1_XH, 8'h4A);
    do_txn("p5_xl", REG_P1_XL, 8'hBC);
    do_txn("p5_yh", REG_P1_YH, 8'h03);
    do_txn("p5_yl", REG_P1_YL, 8'h21);
    check_publish("p5", 1'b1, 12'hABC, 12'h321, 2'b01);

    // Async reset while waiting for a response
    wait_trigger("p6", P + 10, n, tc);
    check("p6_reg", 32'(i2c_reg_out), 32'(REG_TD_STATUS));
    @(negedge clk_in);
    rst_in = 1'b0;
    #1;
    check("arst_i2crst", 32'(i2c_rst_out), 32'd1);
    check("arst_x", 32'(touch_x_out), 32'd0);
    check("arst_y", 32'(touch_y_out), 32'd0);
    check("arst_event", 32'(touch_event_out), 32'd0);
    check("arst_reg", 32'(i2c_reg_out), 32'd0);
    repeat (2) @(negedge clk_in);
    release_and_first_poll("rel", 1'b1, tprev);
    respond("p7_st", REG_TD_STATUS, 8'h00);
    check_publish("p7", 1'b0, 12'h000, 12'h000, 2'b00);

    // Enable dropped mid-poll
    wait_trigger("p8", P + 10, n, tc);
    check("p8_period", 32'(tc - tprev), 32'(P));
    respond("p8_st", REG_TD_STATUS, 8'h01);
    wait_trigger("p8_xh", 8, n, tc);
    enable_in = 1'b0;
    respond("p8_xh", REG_P1_XH, 8'h81);
    do_txn("p8_xl", REG_P1_XL, 8'h2C);
    do_txn("p8_yh", REG_P1_YH, 8'h00);
    do_txn("p8_yl", REG_P1_YL, 8'hF0);
    check_publish("p8", 1'b1, 12'h12C, 12'h0F0, 2'b10);
    n = 0;
    for (int k = 0; k < 2 * P; k++) begin
      @(negedge clk_in);
      if (i2c_trigger_out) n++;
    end
    check("idle_triggers", 32'(n), 32'd0);
    enable_in = 1'b1;
    wait_trigger("p9", P + 10, n, tc);
    check("p9_lat", 32'(n), 32'(P));
    respond("p9_st", REG_TD_STATUS, 8'h00);
    check_publish("p9", 1'b0, 12'h12C, 12'h0F0, 2'b10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
